module_count_display: RTL and testbench

Two-digit 7-segment display driver for the 6-bit counter output. It converts the binary count to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a common-anode 7-segment display. It sits directly downstream of the counter: the counter's `count_o` connects to this block's `count_i`.

---
 rtl/module_count_display.sv | 133 +++++++++++++
 tb/tb_module_count_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/module_count_display.sv
// Two-digit 7-segment driver: sequential double-dabble conversion of a 6-bit count,
// then time-multiplexed common-anode display. Optional macro: LEADING_ZERO_BLANK_EN.
module module_count_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count_i,
  output logic [7:0] bcd_o,
  output logic       busy_o,
  output logic [1:0] an_o,
  output logic [6:0] seg_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t     state, state_nx;
  logic [5:0] last_q, last_nx;
  logic [5:0] bin_q, bin_nx;
  logic [7:0] scr_q, scr_nx;
  logic [7:0] bcd_q, bcd_nx;
  logic [2:0] cnt_q, cnt_nx;
  logic [7:0] adj;

  // busy_o is high from the capture edge until the edge that loads bcd_o;
  // bcd_o holds the previous result for the whole conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_q <= '0;
      bin_q  <= '0;
      scr_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      last_q <= last_nx;
      bin_q  <= bin_nx;
      scr_q  <= scr_nx;
      bcd_q  <= bcd_nx;
      cnt_q  <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last_q;
    bin_nx   = bin_q;
    scr_nx   = scr_q;
    bcd_nx   = bcd_q;
    cnt_nx   = cnt_q;
    adj      = scr_q;
    if (scr_q[3:0] >= 4'd5) adj[3:0] = scr_q[3:0] + 4'd3;
    if (scr_q[7:4] >= 4'd5) adj[7:4] = scr_q[7:4] + 4'd3;
    case (state)
      IDLE: begin
        if (count_i != last_q) begin
          last_nx  = count_i;
          bin_nx   = count_i;
          scr_nx   = '0;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        {scr_nx, bin_nx} = {adj[6:0], bin_q, 1'b0};
        cnt_nx = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_nx = LOAD;
      end
      LOAD: begin
        bcd_nx   = scr_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bcd_o  = bcd_q;
  assign busy_o = (state != IDLE);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0] ref_q;
  logic          sel_q;
  logic          sel_nx;
  logic          wrap;
  logic [3:0]    digit;
  logic [6:0]    seg_q, seg_nx;

  // Segments are computed for the digit that will be active after this edge,
  // so anode and segments switch together.
  always_comb begin
    wrap   = (ref_q == CW'(REFRESH_DIV - 1));
    sel_nx = sel_q ^ wrap;
    digit  = sel_nx ? bcd_q[7:4] : bcd_q[3:0];
    seg_nx = decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_nx && (bcd_q[7:4] == 4'd0)) seg_nx = 7'b1111111;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= '0;
      sel_q <= 1'b0;
      seg_q <= 7'b1000000;
    end else begin
      ref_q <= wrap ? '0 : ref_q + CW'(1);
      sel_q <= sel_nx;
      seg_q <= seg_nx;
    end
  end

  assign an_o  = sel_q ? 2'b01 : 2'b10;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_module_count_display.sv
// Randomised scoreboard bench for module_count_display with REFRESH_DIV = 4.
// Expected BCD results are queued by the drivers and popped when busy_o falls.
module tb_module_count_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] count_i = '0;
  logic [7:0] bcd_o;
  logic       busy_o;
  logic [1:0] an_o;
  logic [6:0] seg_o;

  module_count_display #(.REFRESH_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .count_i (count_i),
    .bcd_o   (bcd_o),
    .busy_o  (busy_o),
    .an_o    (an_o),
    .seg_o   (seg_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         n;
  int         busy_len = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] model_bcd = '0;
  logic [7:0] seg_bcd = '0;
  logic [5:0] last_conv = '0;
  logic [7:0] exp_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    int x;
    x = int'(v);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [7:0] v, input bit tens);
    logic [3:0] d;
    d = tens ? v[7:4] : v[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (tens && d == 4'd0) return 7'b1111111;
`endif
    if (d > 4'd9) return 7'b1111111;
    return seg_tab[d];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // cycles since reset release; display digit = (n / DIV) % 2
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  always @(negedge clk) begin
    bit tens_act;
    logic [7:0] e;
    if (rst) begin
      prev_busy = 1'b0;
      busy_len  = 0;
      model_bcd = '0;
      seg_bcd   = '0;
      chk("reset_bcd", bcd_o, 8'h00);
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_an", an_o, 2'b10);
      chk("reset_seg", seg_o, 7'b1000000);
    end else begin
      tens_act = ((n / DIV) % 2) == 1;
      chk("an", an_o, tens_act ? 2'b01 : 2'b10);
      chk("seg", seg_o, exp_seg(seg_bcd, tens_act));
      if (busy_o) busy_len++;
      if (prev_busy && !busy_o) begin
        chk("busy_len", busy_len, 7);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_conv: got bcd %0h expected no conversion", bcd_o);
        end else begin
          e = exp_q.pop_front();
          chk("bcd", bcd_o, e);
          model_bcd = e;
        end
        done_cnt++;
        busy_len = 0;
      end else begin
        chk("bcd_hold", bcd_o, model_bcd);
      end
      prev_busy = busy_o;
      seg_bcd   = model_bcd;
    end
  end

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL timeout: completed %0d required %0d", done_cnt, target);
    end
  endtask

  task automatic convert(input logic [5:0] v, input int idle);
    int target;
    @(negedge clk);
    count_i = v;
    target = done_cnt;
    if (v != last_conv) begin
      exp_q.push_back(to_bcd(v));
      target++;
      last_conv = v;
    end
    wait_done(target);
    repeat (idle) @(negedge clk);
  endtask

  // a must differ from last_conv so mid and b land inside a's conversion
  task automatic burst(input logic [5:0] a, input logic [5:0] mid, input logic [5:0] b);
    int target;
    @(negedge clk);
    count_i = a;
    exp_q.push_back(to_bcd(a));
    target = done_cnt + 1;
    last_conv = a;
    @(negedge clk);
    count_i = mid;
    @(negedge clk);
    count_i = b;
    if (b != last_conv) begin
      exp_q.push_back(to_bcd(b));
      target++;
      last_conv = b;
    end
    wait_done(target);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int target;
    logic [5:0] a;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // idle at zero: no conversion, display alternates
    repeat (20) @(negedge clk);

    convert(6'd37, 10);
    convert(6'd63, 9);
    convert(6'd9, 9);
    convert(6'd10, 9);
    burst(6'd5, 6'd20, 6'd21);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    count_i = 6'd45;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bcd", bcd_o, 8'h00);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_an", an_o, 2'b10);
    chk("async_rst_seg", seg_o, 7'b1000000);
    exp_q.push_back(to_bcd(6'd45));
    last_conv = 6'd45;
    target = done_cnt + 1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_done(target);
    repeat (9) @(negedge clk);

    for (int i = 0; i < 64; i++) convert(6'(i), $urandom_range(0, 2));

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        convert(6'($urandom_range(0, 63)), $urandom_range(0, 10));
      end else begin
        a = last_conv + 6'($urandom_range(1, 63));
        burst(a, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
